flappy_player_ctrl: RTL



---
 rtl/flappy_player_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/flappy_player_ctrl.sv
// Frame-rate player controller: button jump plus gravity physics, gap collision
// detection and a saturating 2-digit BCD score. State only moves on frame_tick.
`timescale 1ns/1ps
module flappy_player_ctrl #(
    parameter int Y_START        = 290,
    parameter int Y_MIN          = 60,
    parameter int Y_MAX          = 420,
    parameter int JUMP_V         = 6,
    parameter int GRAV           = 1,
    parameter int V_MAX          = 8,
    parameter int SCORE_FRAMES   = 16,
    parameter int RESTART_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_jump,
    input  logic       game_started,
    input  logic [9:0] gap_top,
    input  logic [9:0] gap_bot,
    output logic [9:0] y_pos,
    output logic       crashed,
    output logic       playing,
    output logic [7:0] score
);
    // state    | meaning
    // ST_IDLE  | parked at Y_START, waiting for game_started
    // ST_PLAY  | physics, collision and scoring every frame
    // ST_CRASH | frozen; restart after RESTART_FRAMES frames and a jump
    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_CRASH} state_t;

    localparam int SF_W = $clog2(SCORE_FRAMES);
    localparam int RF_W = $clog2(RESTART_FRAMES + 1);
    localparam logic [SF_W-1:0]   SF_LAST    = SF_W'(SCORE_FRAMES - 1);
    localparam logic [RF_W-1:0]   RF_DONE    = RF_W'(RESTART_FRAMES);
    localparam logic [9:0]        Y_START_V  = 10'(Y_START);
    localparam logic signed [10:0] Y_MIN_S   = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S   = 11'(Y_MAX);
    localparam logic signed [5:0] JUMP_S     = 6'(-JUMP_V);
    localparam logic signed [5:0] GRAV_S     = 6'(GRAV);
    localparam logic signed [5:0] VMAX_S     = 6'(V_MAX);

    state_t            state, state_n;
    logic [2:0]        btn_sync;
    logic              jump_edge, jump_req;
    logic signed [5:0] vel, vel_n, vel_plus, vel_play;
    logic [9:0]        y_n, y_play;
    logic signed [10:0] y_sum;
    logic signed [11:0] box_top;
    logic              hit;
    logic [SF_W-1:0]   frame_cnt, frame_cnt_n;
    logic [RF_W-1:0]   restart_cnt, restart_cnt_n;
    logic [7:0]        score_n, score_inc;

    assign jump_edge = btn_sync[1] & ~btn_sync[2];

    // Physics for a PLAY frame; position is summed wide so clamping never wraps.
    always_comb begin
        vel_plus = vel + GRAV_S;
        vel_play = jump_req ? JUMP_S : ((vel_plus > VMAX_S) ? VMAX_S : vel_plus);
        y_sum    = $signed({1'b0, y_pos}) + $signed({{5{vel_play[5]}}, vel_play});
        if (y_sum < Y_MIN_S) begin
            y_play = 10'(Y_MIN);
        end else if (y_sum > Y_MAX_S) begin
            y_play = 10'(Y_MAX);
        end else begin
            y_play = y_sum[9:0];
        end
        box_top = $signed({2'b00, y_play}) - 12'sd10;
        hit     = (box_top <= $signed({2'b00, gap_top}))
                  || (({2'b00, y_play} + 12'd5) >= {2'b00, gap_bot});
    end

    always_comb begin
        score_inc = score;
        if (score != 8'h99) begin
            if (score[3:0] == 4'd9) begin
                score_inc = {score[7:4] + 4'd1, 4'd0};
            end else begin
                score_inc = {score[7:4], score[3:0] + 4'd1};
            end
        end
    end

    always_comb begin
        state_n       = state;
        y_n           = y_pos;
        vel_n         = vel;
        frame_cnt_n   = frame_cnt;
        restart_cnt_n = restart_cnt;
        score_n       = score;
        if (frame_tick) begin
            case (state)
                ST_IDLE: begin
                    y_n   = Y_START_V;
                    vel_n = '0;
                    if (game_started) begin
                        state_n     = ST_PLAY;
                        score_n     = '0;
                        frame_cnt_n = '0;
                    end
                end
                ST_PLAY: begin
                    if (!game_started) begin
                        state_n = ST_IDLE;
                        y_n     = Y_START_V;
                        vel_n   = '0;
                    end else if (hit) begin
                        state_n       = ST_CRASH;
                        y_n           = y_play;
                        vel_n         = '0;
                        restart_cnt_n = '0;
                    end else begin
                        y_n   = y_play;
                        vel_n = vel_play;
                        if (frame_cnt == SF_LAST) begin
                            frame_cnt_n = '0;
                            score_n     = score_inc;
                        end else begin
                            frame_cnt_n = frame_cnt + SF_W'(1);
                        end
                    end
                end
                ST_CRASH: begin
                    if (!game_started || (restart_cnt == RF_DONE && jump_req)) begin
                        state_n = ST_IDLE;
                        y_n     = Y_START_V;
                        vel_n   = '0;
                    end else if (restart_cnt != RF_DONE) begin
                        restart_cnt_n = restart_cnt + RF_W'(1);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    y_n     = Y_START_V;
                    vel_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            y_pos       <= Y_START_V;
            vel         <= '0;
            crashed     <= 1'b0;
            playing     <= 1'b0;
            score       <= 8'h00;
            btn_sync    <= '0;
            jump_req    <= 1'b0;
            frame_cnt   <= '0;
            restart_cnt <= '0;
        end else begin
            state       <= state_n;
            y_pos       <= y_n;
            vel         <= vel_n;
            crashed     <= (state_n == ST_CRASH);
            playing     <= (state_n == ST_PLAY);
            score       <= score_n;
            btn_sync    <= {btn_sync[1:0], btn_jump};
            // A tick consumes the pending jump; an edge on the tick survives it.
            jump_req    <= jump_edge | (jump_req & ~frame_tick);
            frame_cnt   <= frame_cnt_n;
            restart_cnt <= restart_cnt_n;
        end
    end
endmodule
